// File: rtl/md5_mem_responder.sv
// Dual-channel word RAM responder for the md5 core's memory port.
// Define MD5_MEM_SNOOP_EN to add the snoop_valid/snoop_addr/snoop_data write-tap outputs.
module md5_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Mout_oe_ram,
    input  logic [1:0]  Mout_we_ram,
    input  logic [63:0] Mout_addr_ram,
    input  logic [63:0] Mout_Wdata_ram,
    input  logic [11:0] Mout_data_ram_size,
    output logic [63:0] M_Rdata_ram,
    output logic [1:0]  M_DataRdy,
    output logic        err
`ifdef MD5_MEM_SNOOP_EN
    ,
    output logic        snoop_valid,
    output logic [31:0] snoop_addr,
    output logic [31:0] snoop_data
`endif
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
    localparam logic [2:0]  WAIT_LOAD = 3'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } ch_state_t;

    ch_state_t state_q [2];
    ch_state_t state_d [2];
    logic [1:0][2:0]    cnt_q;
    logic [1:0][2:0]    cnt_d;
    logic [1:0][31:0]   rdata_q;

    logic [31:0] mem [DEPTH];

    logic [1:0][31:0]   addr;
    logic [1:0][31:0]   wdata;
    logic [1:0][31:0]   off;
    logic [1:0][5:0]    size;
    logic [1:0][AW-1:0] word;
    logic [1:0][1:0]    lane;
    logic [1:0][3:0]    be;
    logic [1:0][31:0]   wlane;
    logic [1:0][31:0]   rword;
    logic [1:0][31:0]   rval;
    logic [1:0]         in_range;
    logic [1:0]         accept;
    logic [1:0]         do_wr;
    logic [1:0]         do_rd;
    logic [1:0]         bad;

    // Address/size decode; illegal sizes fall through to the full-word path.
    always_comb begin
        addr     = Mout_addr_ram;
        wdata    = Mout_Wdata_ram;
        size     = Mout_data_ram_size;
        off      = '0;
        word     = '0;
        lane     = '0;
        be       = '0;
        wlane    = '0;
        rword    = '0;
        rval     = '0;
        in_range = '0;
        accept   = '0;
        do_wr    = '0;
        do_rd    = '0;
        bad      = '0;
        for (int i = 0; i < 2; i++) begin
            off[i]      = addr[i] - BASE_ADDR;
            in_range[i] = off[i] < SPAN;
            word[i]     = off[i][AW+1:2];
            lane[i]     = off[i][1:0];
            rword[i]    = mem[word[i]];
            accept[i]   = (state_q[i] == S_IDLE) && (Mout_oe_ram[i] || Mout_we_ram[i]);
            do_wr[i]    = accept[i] && Mout_we_ram[i] && in_range[i];
            do_rd[i]    = accept[i] && Mout_oe_ram[i] && !Mout_we_ram[i];
            case (size[i])
                6'd8: begin
                    be[i]    = 4'b0001 << lane[i];
                    wlane[i] = {4{wdata[i][7:0]}};
                    rval[i]  = (rword[i] >> {lane[i], 3'b000}) & 32'h0000_00FF;
                end
                6'd16: begin
                    be[i]    = lane[i][1] ? 4'b1100 : 4'b0011;
                    wlane[i] = {2{wdata[i][15:0]}};
                    rval[i]  = (rword[i] >> {lane[i][1], 4'b0000}) & 32'h0000_FFFF;
                end
                default: begin
                    be[i]    = 4'b1111;
                    wlane[i] = wdata[i];
                    rval[i]  = rword[i];
                end
            endcase
            if (!in_range[i]) begin
                rval[i] = '0;
            end
            bad[i] = accept[i] && ((Mout_oe_ram[i] && Mout_we_ram[i]) || !in_range[i] ||
                     !(size[i] == 6'd8 || size[i] == 6'd16 || size[i] == 6'd32));
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (accept[i]) begin
                        if (LATENCY > 1) begin
                            state_d[i] = S_WAIT;
                            cnt_d[i]   = WAIT_LOAD;
                        end else begin
                            state_d[i] = S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q[i] == 3'd0) begin
                        state_d[i] = S_RESP;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 3'd1;
                    end
                end
                S_RESP:  state_d[i] = S_IDLE;
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        M_DataRdy = '0;
        for (int i = 0; i < 2; i++) begin
            M_DataRdy[i] = (state_q[i] == S_RESP);
        end
    end

    assign M_Rdata_ram = {rdata_q[1], rdata_q[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q[0] <= S_IDLE;
            state_q[1] <= S_IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err        <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                if (do_rd[i]) begin
                    rdata_q[i] <= rval[i];
                end
            end
            if (|bad) begin
                err <= 1'b1;
            end
        end
    end

    // Channel 1 is written last so its bytes win on a same-word collision.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset && do_wr[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[i][b]) begin
                        mem[word[i]][8*b +: 8] <= wlane[i][8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef MD5_MEM_SNOOP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snoop_valid <= 1'b0;
            snoop_addr  <= '0;
            snoop_data  <= '0;
        end else begin
            snoop_valid <= |do_wr;
            if (do_wr[1]) begin
                snoop_addr <= addr[1];
                snoop_data <= wdata[1];
            end else if (do_wr[0]) begin
                snoop_addr <= addr[0];
                snoop_data <= wdata[0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_md5_mem_responder.sv
// Bench for md5_mem_responder: LATENCY=1 and LATENCY=3 instances side by side against a
// byte-array memory model; snoop outputs are checked too when MD5_MEM_SNOOP_EN is defined.
module tb_md5_mem_responder;

    localparam logic [31:0] BASE  = 32'h40000000;
    localparam int          DEPTH = 256;
    localparam int          NB    = DEPTH * 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  oe_s    [2];
    logic [1:0]  we_s    [2];
    logic [63:0] addr_s  [2];
    logic [63:0] wdata_s [2];
    logic [11:0] size_s  [2];
    logic [63:0] rdata   [2];
    logic [1:0]  rdy     [2];
    logic        err_s   [2];
`ifdef MD5_MEM_SNOOP_EN
    logic        sv_s [2];
    logic [31:0] sa_s [2];
    logic [31:0] sd_s [2];
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit live     = 1'b0;

    always #5 clk = ~clk;

    md5_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .Mout_oe_ram(oe_s[0]), .Mout_we_ram(we_s[0]), .Mout_addr_ram(addr_s[0]),
        .Mout_Wdata_ram(wdata_s[0]), .Mout_data_ram_size(size_s[0]),
        .M_Rdata_ram(rdata[0]), .M_DataRdy(rdy[0]), .err(err_s[0])
`ifdef MD5_MEM_SNOOP_EN
        , .snoop_valid(sv_s[0]), .snoop_addr(sa_s[0]), .snoop_data(sd_s[0])
`endif
    );

    md5_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset),
        .Mout_oe_ram(oe_s[1]), .Mout_we_ram(we_s[1]), .Mout_addr_ram(addr_s[1]),
        .Mout_Wdata_ram(wdata_s[1]), .Mout_data_ram_size(size_s[1]),
        .M_Rdata_ram(rdata[1]), .M_DataRdy(rdy[1]), .err(err_s[1])
`ifdef MD5_MEM_SNOOP_EN
        , .snoop_valid(sv_s[1]), .snoop_addr(sa_s[1]), .snoop_data(sd_s[1])
`endif
    );

    // Reference model: byte memory, per-channel completion edge and earliest next acceptance.
    logic [7:0]  mdl     [2][NB];
    int          edge_no = 0;
    int          rdy_edge [2][2];
    int          next_ok  [2][2];
    logic [31:0] exp_rd   [2][2];
    logic        exp_err  [2];
    logic        exp_sv   [2];
    logic [31:0] exp_sa   [2];
    logic [31:0] exp_sd   [2];
    logic        acc_m    [2];

    function automatic int lat_of(int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] mdl_read(int g, logic [31:0] a, logic [5:0] sz);
        logic [31:0] off;
        off = a - BASE;
        if (off >= NB) return 32'h0;
        if (sz == 6'd8) return {24'h0, mdl[g][off]};
        if (sz == 6'd16) begin
            off[0] = 1'b0;
            return {16'h0, mdl[g][off+1], mdl[g][off]};
        end
        off[1:0] = 2'b00;
        return {mdl[g][off+3], mdl[g][off+2], mdl[g][off+1], mdl[g][off]};
    endfunction

    function automatic void mdl_write(int g, logic [31:0] a, logic [31:0] d, logic [5:0] sz);
        logic [31:0] off;
        off = a - BASE;
        if (off >= NB) return;
        if (sz == 6'd8) begin
            mdl[g][off] = d[7:0];
        end else if (sz == 6'd16) begin
            off[0] = 1'b0;
            mdl[g][off]   = d[7:0];
            mdl[g][off+1] = d[15:8];
        end else begin
            off[1:0] = 2'b00;
            for (int b = 0; b < 4; b++) mdl[g][off+b] = d[8*b +: 8];
        end
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!reset) begin
                for (int c = 0; c < 2; c++) begin
                    rdy_edge[g][c] = -100;
                    next_ok[g][c]  = 0;
                    exp_rd[g][c]   = 32'h0;
                end
                exp_err[g] = 1'b0;
                exp_sv[g]  = 1'b0;
                exp_sa[g]  = 32'h0;
                exp_sd[g]  = 32'h0;
            end else begin
                exp_sv[g] = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    logic [31:0] a;
                    logic [5:0]  sz;
                    a  = addr_s[g][32*c +: 32];
                    sz = size_s[g][6*c +: 6];
                    acc_m[c] = (edge_no >= next_ok[g][c]) && (oe_s[g][c] || we_s[g][c]);
                    if (acc_m[c]) begin
                        rdy_edge[g][c] = edge_no + lat_of(g) - 1;
                        next_ok[g][c]  = edge_no + lat_of(g) + 1;
                        if ((oe_s[g][c] && we_s[g][c]) || (a - BASE) >= NB ||
                            !(sz == 6'd8 || sz == 6'd16 || sz == 6'd32))
                            exp_err[g] = 1'b1;
                        if (oe_s[g][c] && !we_s[g][c])
                            exp_rd[g][c] = mdl_read(g, a, sz);
                    end
                end
                for (int c = 0; c < 2; c++) begin
                    logic [31:0] a;
                    a = addr_s[g][32*c +: 32];
                    if (acc_m[c] && we_s[g][c]) begin
                        mdl_write(g, a, wdata_s[g][32*c +: 32], size_s[g][6*c +: 6]);
                        if ((a - BASE) < NB) begin
                            exp_sv[g] = 1'b1;
                            exp_sa[g] = a;
                            exp_sd[g] = wdata_s[g][32*c +: 32];
                        end
                    end
                end
            end
        end
        edge_no++;
    end

    function automatic void check_output(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    always @(negedge clk) begin
        if (live) begin
            for (int g = 0; g < 2; g++) begin
                for (int c = 0; c < 2; c++)
                    check_output($sformatf("rdy L%0d ch%0d", lat_of(g), c), 64'(rdy[g][c]),
                                 64'((edge_no - 1) == rdy_edge[g][c]));
                check_output($sformatf("rdata L%0d", lat_of(g)), rdata[g],
                             {exp_rd[g][1], exp_rd[g][0]});
                check_output($sformatf("err L%0d", lat_of(g)), 64'(err_s[g]), 64'(exp_err[g]));
`ifdef MD5_MEM_SNOOP_EN
                check_output($sformatf("snoop_valid L%0d", lat_of(g)), 64'(sv_s[g]), 64'(exp_sv[g]));
                check_output($sformatf("snoop_addr L%0d", lat_of(g)), 64'(sa_s[g]), 64'(exp_sa[g]));
                check_output($sformatf("snoop_data L%0d", lat_of(g)), 64'(sd_s[g]), 64'(exp_sd[g]));
`endif
            end
        end
    end

    task automatic clear_inputs();
        for (int g = 0; g < 2; g++) begin
            oe_s[g] = 2'b00;
            we_s[g] = 2'b00;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Drives both instances identically, holding each until it reports ready.
    task automatic apply_stimulus(input logic [1:0] o, input logic [1:0] w,
                                  input logic [63:0] a, input logic [63:0] d,
                                  input logic [11:0] s, output int lat_seen [2]);
        logic busy [2];
        int   cyc;
        @(negedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            oe_s[g] = o; we_s[g] = w; addr_s[g] = a; wdata_s[g] = d; size_s[g] = s;
            busy[g] = 1'b1;
            lat_seen[g] = -1;
        end
        cyc = 0;
        while ((busy[0] || busy[1]) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) begin
                if (busy[g] && ((rdy[g] & (o | w)) == (o | w))) begin
                    busy[g] = 1'b0;
                    lat_seen[g] = cyc;
                    oe_s[g] = 2'b00;
                    we_s[g] = 2'b00;
                end
            end
        end
        for (int g = 0; g < 2; g++)
            check_output($sformatf("ready_timeout L%0d", lat_of(g)), 64'(busy[g]), 64'(0));
        clear_inputs();
    endtask

    task automatic expect_rd(string name, int c, logic [31:0] v);
        for (int g = 0; g < 2; g++)
            check_output($sformatf("%s L%0d", name, lat_of(g)), 64'(rdata[g][32*c +: 32]), 64'(v));
    endtask

    task automatic expect_err(logic v);
        for (int g = 0; g < 2; g++)
            check_output($sformatf("err_literal L%0d", lat_of(g)), 64'(err_s[g]), 64'(v));
    endtask

    initial begin
        int  lat [2];
        bit  seen;
        for (int g = 0; g < 2; g++) begin
            oe_s[g] = 2'b00; we_s[g] = 2'b00; addr_s[g] = '0; wdata_s[g] = '0; size_s[g] = '0;
        end
        repeat (3) @(negedge clk);
        live = 1'b1;
        #1;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check_output("idle_rdy", 64'(rdy[g]), 64'(0));
            check_output("idle_rdata", rdata[g], 64'(0));
        end
        expect_err(1'b0);

        apply_stimulus(2'b00, 2'b01, {32'h0, 32'h40000000}, {32'h0, 32'h00000080}, {6'd0, 6'd32}, lat);
        apply_stimulus(2'b01, 2'b00, {32'h0, 32'h40000000}, 64'h0, {6'd0, 6'd32}, lat);
        expect_rd("rd_0x80", 0, 32'h00000080);
        check_output("latency_L1", 64'(lat[0]), 64'(1));
        check_output("latency_L3", 64'(lat[1]), 64'(3));

        apply_stimulus(2'b00, 2'b11, {32'h40000100, 32'h40000100}, {32'h55555555, 32'hAAAAAAAA},
                       {6'd32, 6'd32}, lat);
        apply_stimulus(2'b01, 2'b00, {32'h0, 32'h40000100}, 64'h0, {6'd0, 6'd32}, lat);
        expect_rd("ch1_wins", 0, 32'h55555555);
        apply_stimulus(2'b00, 2'b10, {32'h40000103, 32'h0}, {32'h00000012, 32'h0}, {6'd8, 6'd0}, lat);
        apply_stimulus(2'b01, 2'b00, {32'h0, 32'h40000100}, 64'h0, {6'd0, 6'd32}, lat);
        expect_rd("byte_merge", 0, 32'h12555555);
        apply_stimulus(2'b11, 2'b00, {32'h40000102, 32'h40000101}, 64'h0, {6'd16, 6'd8}, lat);
        expect_rd("half_rd", 1, 32'h00001255);
        expect_rd("byte_rd", 0, 32'h00000055);

        apply_stimulus(2'b01, 2'b10, {32'h40000100, 32'h40000100}, {32'hCAFEF00D, 32'h0},
                       {6'd32, 6'd32}, lat);
        expect_rd("rd_prewrite", 0, 32'h12555555);
        apply_stimulus(2'b10, 2'b00, {32'h40000100, 32'h0}, 64'h0, {6'd32, 6'd0}, lat);
        expect_rd("rd_postwrite", 1, 32'hCAFEF00D);

        apply_stimulus(2'b00, 2'b01, {32'h0, 32'h40000104}, 64'h0, {6'd0, 6'd32}, lat);
        apply_stimulus(2'b00, 2'b01, {32'h0, 32'h40000106}, {32'h0, 32'h0000BEEF}, {6'd0, 6'd16}, lat);
        apply_stimulus(2'b01, 2'b00, {32'h0, 32'h40000104}, 64'h0, {6'd0, 6'd32}, lat);
        expect_rd("half_wr", 0, 32'hBEEF0000);

        apply_stimulus(2'b00, 2'b11, {32'h40000204, 32'h40000200}, {32'h04b2008f, 32'hd98c1dd4},
                       {6'd32, 6'd32}, lat);
        apply_stimulus(2'b00, 2'b11, {32'h4000020C, 32'h40000208}, {32'h7e42f8ec, 32'h980980e9},
                       {6'd32, 6'd32}, lat);
        apply_stimulus(2'b11, 2'b00, {32'h40000204, 32'h40000200}, 64'h0, {6'd32, 6'd32}, lat);
        expect_rd("digest0", 0, 32'hd98c1dd4);
        expect_rd("digest1", 1, 32'h04b2008f);
        apply_stimulus(2'b11, 2'b00, {32'h4000020C, 32'h40000208}, 64'h0, {6'd32, 6'd32}, lat);
        expect_rd("digest2", 0, 32'h980980e9);
        expect_rd("digest3", 1, 32'h7e42f8ec);
        expect_err(1'b0);

        apply_stimulus(2'b00, 2'b01, {32'h0, 32'h40000300}, {32'h0, 32'h11223344}, {6'd0, 6'd24}, lat);
        expect_err(1'b1);
        apply_stimulus(2'b01, 2'b00, {32'h0, 32'h40000300}, 64'h0, {6'd0, 6'd32}, lat);
        expect_rd("bad_size_as32", 0, 32'h11223344);

        apply_reset();
        expect_err(1'b0);
        apply_stimulus(2'b10, 2'b10, {32'h40000304, 32'h0}, {32'hDEADBEEF, 32'h0}, {6'd32, 6'd0}, lat);
        expect_err(1'b1);
        apply_stimulus(2'b10, 2'b00, {32'h40000304, 32'h0}, 64'h0, {6'd32, 6'd0}, lat);
        expect_rd("oe_we_as_write", 1, 32'hDEADBEEF);

        apply_reset();
        apply_stimulus(2'b10, 2'b00, {32'h40000000, 32'h0}, 64'h0, {6'd32, 6'd0}, lat);
        expect_rd("pre_oor", 1, 32'h00000080);
        apply_stimulus(2'b10, 2'b00, {32'h3FFFFFFC, 32'h0}, 64'h0, {6'd32, 6'd0}, lat);
        expect_rd("oor_rd", 1, 32'h00000000);
        expect_err(1'b1);
        repeat (100) @(negedge clk);
        expect_err(1'b1);

        @(negedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            oe_s[g] = 2'b01; addr_s[g] = {32'h0, 32'h40000000}; size_s[g] = {6'd0, 6'd32};
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= rdy[1][0];
        end
        #1;
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen |= rdy[1][0];
        end
        check_output("no_pulse_after_reset", 64'(seen), 64'(0));
        apply_stimulus(2'b01, 2'b00, {32'h0, 32'h40000000}, 64'h0, {6'd0, 6'd32}, lat);
        expect_rd("rd_after_reset", 0, 32'h00000080);
        check_output("latency_L3_after_reset", 64'(lat[1]), 64'(3));

        repeat (2) @(negedge clk);
        live = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
